// File: rtl/rr_pkg.sv
// rtl/rr_pkg.sv - shared constants and state type for the weighted round-robin arbiter
package rr_pkg;

    localparam int NUM_REQ    = 4;
    localparam int WW_DEFAULT = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority picker over a 4-bit eligible mask
module rr_pick
    import rr_pkg::*;
(
    input  logic [NUM_REQ-1:0] elig_i,
    input  logic [1:0]         start_i,
    output logic               valid_o,
    output logic [1:0]         idx_o
);

    logic [1:0] cand;

    // Walk from the farthest offset back to start so the nearest hit wins.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = start_i + 2'(k);
            if (elig_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/wrr_arbiter.sv
// rtl/wrr_arbiter.sv - four-way weighted round-robin arbiter with runtime weight config
module wrr_arbiter
    import rr_pkg::*;
#(
    parameter int WW             = WW_DEFAULT,
    parameter int DEFAULT_WEIGHT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req3,
    input  logic          req2,
    input  logic          req1,
    input  logic          req0,
    input  logic          cfg_we,
    input  logic [1:0]    cfg_sel,
    input  logic [WW-1:0] cfg_weight,
    output logic          gnt3,
    output logic          gnt2,
    output logic          gnt1,
    output logic          gnt0,
    output logic [1:0]    gnt_id,
    output logic          busy
);

    state_e               state_q, state_d;
    logic [1:0]           owner_q, owner_d;
    logic [1:0]           ptr_q, ptr_d;
    logic [WW-1:0]        cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [WW-1:0]        weight_q [NUM_REQ];

    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   elig;
    logic                 expire;
    logic [1:0]           pick_start;
    logic                 pick_valid;
    logic [1:0]           pick_idx;

    assign req = {req3, req2, req1, req0};

    // Eligibility uses the registered weights, so a same-cycle write is not seen.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = req[i] && (weight_q[i] != '0);
        end
    end

    assign expire     = (state_q == GRANT) && req[owner_q] && (cnt_q == '0);
    assign pick_start = expire ? (owner_q + 2'd1) : ptr_q;

    rr_pick u_pick (
        .elig_i  (elig),
        .start_i (pick_start),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = GRANT;
                    owner_d = pick_idx;
                    gnt_d   = NUM_REQ'(1) << pick_idx;
                    cnt_d   = weight_q[pick_idx] - WW'(1);
                    ptr_d   = pick_idx + 2'd1;
                end
            end
            GRANT: begin
                if (!req[owner_q] || expire) begin
                    if (pick_valid) begin
                        owner_d = pick_idx;
                        gnt_d   = NUM_REQ'(1) << pick_idx;
                        cnt_d   = weight_q[pick_idx] - WW'(1);
                        ptr_d   = pick_idx + 2'd1;
                    end else begin
                        state_d = IDLE;
                        owner_d = '0;
                        gnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - WW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = '0;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                weight_q[i] <= WW'(DEFAULT_WEIGHT);
            end
        end else if (cfg_we) begin
            weight_q[cfg_sel] <= cfg_weight;
        end
    end

    assign {gnt3, gnt2, gnt1, gnt0} = gnt_q;
    assign gnt_id = owner_q;
    assign busy   = |gnt_q;

endmodule

// File: tb/tb_wrr_arbiter.sv
// tb/tb_wrr_arbiter.sv - scoreboard bench for wrr_arbiter against a quota-counting model
module tb_wrr_arbiter;

    localparam int WW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req3 = 1'b0, req2 = 1'b0, req1 = 1'b0, req0 = 1'b0;
    logic          cfg_we = 1'b0;
    logic [1:0]    cfg_sel = '0;
    logic [WW-1:0] cfg_weight = '0;
    logic          gnt3, gnt2, gnt1, gnt0;
    logic [1:0]    gnt_id;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] id;
        logic       busy;
    } exp_t;
    exp_t exp_q[$];

    // Model: owner holds for 'quota' cycles, counted up from the grant cycle.
    int m_owner;
    int m_used;
    int m_quota;
    int m_ptr;
    int m_w [4];

    wrr_arbiter #(.WW(WW), .DEFAULT_WEIGHT(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req3       (req3),
        .req2       (req2),
        .req1       (req1),
        .req0       (req0),
        .cfg_we     (cfg_we),
        .cfg_sel    (cfg_sel),
        .cfg_weight (cfg_weight),
        .gnt3       (gnt3),
        .gnt2       (gnt2),
        .gnt1       (gnt1),
        .gnt0       (gnt0),
        .gnt_id     (gnt_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_used  = 0;
        m_quota = 0;
        m_ptr   = 0;
        for (int i = 0; i < 4; i++) m_w[i] = 1;
    endtask

    function automatic int pick(input logic [3:0] r, input int start);
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (start + k) % 4;
            if (r[idx] && m_w[idx] != 0) return idx;
        end
        return -1;
    endfunction

    task automatic model_grant(input int p);
        if (p >= 0) begin
            m_owner = p;
            m_used  = 1;
            m_quota = m_w[p];
            m_ptr   = (p + 1) % 4;
        end else begin
            m_owner = -1;
        end
    endtask

    // Apply inputs for one edge, predict the post-edge outputs, then take the edge.
    task automatic step(input logic [3:0] r, input logic we, input logic [1:0] sel, input int w);
        exp_t e;
        @(negedge clk);
        {req3, req2, req1, req0} = r;
        cfg_we     = we;
        cfg_sel    = sel;
        cfg_weight = w[WW-1:0];
        if (m_owner < 0) begin
            model_grant(pick(r, m_ptr));
        end else if (!r[m_owner]) begin
            model_grant(pick(r, m_ptr));
        end else if (m_used >= m_quota) begin
            model_grant(pick(r, m_owner + 1));
        end else begin
            m_used++;
        end
        if (we) m_w[sel] = w % (1 << WW);
        e.gnt  = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        e.id   = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
        e.busy = (m_owner >= 0);
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("gnt",    int'({gnt3, gnt2, gnt1, gnt0}), int'(e.gnt));
                check("gnt_id", int'(gnt_id), int'(e.id));
                check("busy",   int'(busy), int'(e.busy));
            end
        end
    end

    initial begin
        logic [3:0] r;
        model_reset();
        #12;
        check("reset_gnt",  int'({gnt3, gnt2, gnt1, gnt0}), 0);
        check("reset_id",   int'(gnt_id), 0);
        check("reset_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;

        repeat (8) step(4'b0011, 1'b0, 2'd0, 0);
        repeat (2) step(4'b0000, 1'b0, 2'd0, 0);

        step(4'b0000, 1'b1, 2'd0, 3);
        step(4'b0000, 1'b1, 2'd1, 1);
        repeat (12) step(4'b0011, 1'b0, 2'd0, 0);
        repeat (2) step(4'b0000, 1'b0, 2'd0, 0);

        step(4'b0000, 1'b1, 2'd2, 2);
        repeat (10) step(4'b0100, 1'b0, 2'd0, 0);
        step(4'b0000, 1'b0, 2'd0, 0);

        step(4'b0000, 1'b1, 2'd0, 4);
        step(4'b0001, 1'b0, 2'd0, 0);
        step(4'b1001, 1'b0, 2'd0, 0);
        repeat (3) step(4'b1000, 1'b0, 2'd0, 0);
        step(4'b0000, 1'b0, 2'd0, 0);

        step(4'b0000, 1'b1, 2'd1, 0);
        repeat (8) step(4'b0010, 1'b0, 2'd0, 0);
        step(4'b0010, 1'b1, 2'd1, 1);
        repeat (3) step(4'b0010, 1'b0, 2'd0, 0);
        step(4'b0000, 1'b0, 2'd0, 0);

        step(4'b0000, 1'b1, 2'd2, 2);
        repeat (3) step(4'b0100, 1'b0, 2'd0, 0);
        #3;
        check("pre_reset_gnt2", int'(gnt2), 1);
        rst = 1'b1;
        #1;
        check("async_rst_gnt",  int'({gnt3, gnt2, gnt1, gnt0}), 0);
        check("async_rst_id",   int'(gnt_id), 0);
        check("async_rst_busy", int'(busy), 0);
        @(negedge clk);
        {req3, req2, req1, req0} = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (8) step(4'b1111, 1'b0, 2'd0, 0);

        r = 4'b0000;
        for (int n = 0; n < 600; n++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 4) == 0) r[b] = ~r[b];
            end
            step(r, ($urandom_range(0, 9) == 0), 2'($urandom_range(0, 3)),
                 int'($urandom_range(0, 4)));
        end
        step(4'b0000, 1'b0, 2'd0, 0);

        @(posedge clk);
        #2;
        if (exp_q.size() != 0) check("scoreboard_drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
